// File: rtl/dmem_arbiter.sv
// Two-requester access controller for a 256 x 32-bit byte-masked data memory.
// Latency: grant and memory drive are combinational in the request cycle; the response (rvalid/rdata/err) follows one cycle later.
// Backpressure: requesters hold req until granted; responses are never stalled.
//
// Ports:
//   clk, rst                       rising-edge clock, asynchronous active-high reset
//   mN_req/we/addr/size/unsigned   request from requester N (0 = core LSU, 1 = debug/DMA)
//   mN_wdata                       LSB-aligned store data
//   mN_gnt                         combinational accept for this cycle
//   mN_rvalid/rdata/err            registered response, one cycle after grant
//   mem_en/address/storein/mask    write port towards the memory (word index, lane-replicated data)
//   mem_loadout                    combinational read data for mem_address
//
// Build option: define DMEM_ARB_FIXED_PRIO_EN to give requester 0 absolute
// priority instead of round-robin; the round-robin pointer is then removed.

module dmem_arbiter #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [1:0]        m0_size,
    input  logic              m0_unsigned,
    input  logic [31:0]       m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rdata,
    output logic              m0_err,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [1:0]        m1_size,
    input  logic              m1_unsigned,
    input  logic [31:0]       m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rdata,
    output logic              m1_err,

    output logic              mem_en,
    output logic [ADDR_W-3:0] mem_address,
    output logic [31:0]       mem_storein,
    output logic [3:0]        mem_mask,
    input  logic [31:0]       mem_loadout
);

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic w_gnt0;
    logic w_gnt1;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    // Requester 0 always wins; requester 1 only sees idle cycles of requester 0.
    always_comb begin
        w_gnt0 = m0_req;
        w_gnt1 = m1_req && !m0_req;
    end
`else
    // r_rr_last holds the index granted most recently; on contention the
    // other requester wins. Reset value 1 makes requester 0 win first.
    logic r_rr_last;

    always_comb begin
        w_gnt0 = m0_req && (!m1_req || r_rr_last);
        w_gnt1 = m1_req && (!m0_req || !r_rr_last);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_last <= 1'b1;
        end else if (w_gnt0) begin
            r_rr_last <= 1'b0;
        end else if (w_gnt1) begin
            r_rr_last <= 1'b1;
        end
    end
`endif

    assign m0_gnt = w_gnt0;
    assign m1_gnt = w_gnt1;

    // ------------------------------------------------------------------
    // Mux the granted request onto a single access path
    // ------------------------------------------------------------------
    logic              w_any;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [1:0]        w_size;
    logic              w_uns;
    logic [31:0]       w_wdata;
    logic [1:0]        w_off;
    logic              w_mis;

    always_comb begin
        w_any   = w_gnt0 || w_gnt1;
        w_we    = 1'b0;
        w_addr  = '0;
        w_size  = SZ_BYTE;
        w_uns   = 1'b0;
        w_wdata = '0;
        if (w_gnt0) begin
            w_we    = m0_we;
            w_addr  = m0_addr;
            w_size  = m0_size;
            w_uns   = m0_unsigned;
            w_wdata = m0_wdata;
        end else if (w_gnt1) begin
            w_we    = m1_we;
            w_addr  = m1_addr;
            w_size  = m1_size;
            w_uns   = m1_unsigned;
            w_wdata = m1_wdata;
        end
    end

    assign w_off = w_addr[1:0];

    // Size 3 is never legal; half needs even offset; word needs offset 0.
    assign w_mis = ((w_size == SZ_HALF) && w_off[0])
                || ((w_size == SZ_WORD) && (w_off != 2'd0))
                || (w_size == 2'd3);

    // ------------------------------------------------------------------
    // Memory write port
    // ------------------------------------------------------------------
    always_comb begin
        mem_en      = 1'b0;
        mem_address = '0;
        mem_storein = '0;
        mem_mask    = 4'b0000;
        if (w_any) begin
            // Address is presented for every granted access, including
            // loads and misaligned ones; only the write side is suppressed.
            mem_address = w_addr[ADDR_W-1:2];
            if (w_we && !w_mis) begin
                mem_en = 1'b1;
                // Store data is replicated across all lanes so the mask alone
                // selects the destination bytes.
                case (w_size)
                    SZ_BYTE: begin
                        mem_mask    = 4'b0001 << w_off;
                        mem_storein = {4{w_wdata[7:0]}};
                    end
                    SZ_HALF: begin
                        mem_mask    = w_off[1] ? 4'b1100 : 4'b0011;
                        mem_storein = {2{w_wdata[15:0]}};
                    end
                    default: begin
                        mem_mask    = 4'b1111;
                        mem_storein = w_wdata;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Load formatting (combinational read in the grant cycle)
    // ------------------------------------------------------------------
    logic [31:0] w_byte_sh;
    logic [15:0] w_half;
    logic [31:0] w_fmt;

    assign w_byte_sh = mem_loadout >> {w_off, 3'b000};
    assign w_half    = w_off[1] ? mem_loadout[31:16] : mem_loadout[15:0];

    always_comb begin
        w_fmt = '0;
        case (w_size)
            SZ_BYTE: w_fmt = w_uns ? {24'd0, w_byte_sh[7:0]}
                                   : {{24{w_byte_sh[7]}}, w_byte_sh[7:0]};
            SZ_HALF: w_fmt = w_uns ? {16'd0, w_half}
                                   : {{16{w_half[15]}}, w_half};
            default: w_fmt = mem_loadout;
        endcase
        // Stores and faulting accesses return zero data.
        if (w_we || w_mis) begin
            w_fmt = '0;
        end
    end

    // ------------------------------------------------------------------
    // Registered responses
    // ------------------------------------------------------------------
    logic        r_rvalid0;
    logic        r_err0;
    logic [31:0] r_rdata0;
    logic        r_rvalid1;
    logic        r_err1;
    logic [31:0] r_rdata1;

    // Async reset also kills a response that is already on the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rvalid0 <= 1'b0;
            r_err0    <= 1'b0;
            r_rdata0  <= '0;
            r_rvalid1 <= 1'b0;
            r_err1    <= 1'b0;
            r_rdata1  <= '0;
        end else begin
            r_rvalid0 <= w_gnt0;
            r_err0    <= w_gnt0 && w_mis;
            r_rdata0  <= w_gnt0 ? w_fmt : 32'd0;
            r_rvalid1 <= w_gnt1;
            r_err1    <= w_gnt1 && w_mis;
            r_rdata1  <= w_gnt1 ? w_fmt : 32'd0;
        end
    end

    assign m0_rvalid = r_rvalid0;
    assign m0_err    = r_err0;
    assign m0_rdata  = r_rdata0;
    assign m1_rvalid = r_rvalid1;
    assign m1_err    = r_err1;
    assign m1_rdata  = r_rdata1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed accesses push expected
// responses, a negedge monitor pops and compares them on every rvalid.
// Memory is modelled here as a byte-masked 256 x 32 array.

module tb_dmem_arbiter;

    logic        clk;
    logic        rst;

    logic        m0_req, m0_we, m0_unsigned;
    logic [9:0]  m0_addr;
    logic [1:0]  m0_size;
    logic [31:0] m0_wdata;
    logic        m0_gnt, m0_rvalid, m0_err;
    logic [31:0] m0_rdata;

    logic        m1_req, m1_we, m1_unsigned;
    logic [9:0]  m1_addr;
    logic [1:0]  m1_size;
    logic [31:0] m1_wdata;
    logic        m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m1_rdata;

    logic        mem_en;
    logic [7:0]  mem_address;
    logic [31:0] mem_storein;
    logic [3:0]  mem_mask;
    logic [31:0] mem_loadout;

    logic [31:0] mem [256];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    dmem_arbiter #(.ADDR_W(10)) dut (
        .clk         (clk),
        .rst         (rst),
        .m0_req      (m0_req),
        .m0_we       (m0_we),
        .m0_addr     (m0_addr),
        .m0_size     (m0_size),
        .m0_unsigned (m0_unsigned),
        .m0_wdata    (m0_wdata),
        .m0_gnt      (m0_gnt),
        .m0_rvalid   (m0_rvalid),
        .m0_rdata    (m0_rdata),
        .m0_err      (m0_err),
        .m1_req      (m1_req),
        .m1_we       (m1_we),
        .m1_addr     (m1_addr),
        .m1_size     (m1_size),
        .m1_unsigned (m1_unsigned),
        .m1_wdata    (m1_wdata),
        .m1_gnt      (m1_gnt),
        .m1_rvalid   (m1_rvalid),
        .m1_rdata    (m1_rdata),
        .m1_err      (m1_err),
        .mem_en      (mem_en),
        .mem_address (mem_address),
        .mem_storein (mem_storein),
        .mem_mask    (mem_mask),
        .mem_loadout (mem_loadout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign mem_loadout = mem[mem_address];

    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_mask[b]) mem[mem_address][8*b +: 8] <= mem_storein[8*b +: 8];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int m, input logic [31:0] rdata, input logic err);
        exp_t e;
        e.rdata = rdata;
        e.err   = err;
        e.due   = cyc + 1;
        if (m == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic mon_pop(input int m, input logic [31:0] rdata, input logic err);
        exp_t e;
        tests++;
        if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
            fails++;
            $display("FAIL m%0d unexpected rvalid: got 1, expected 0 (cycle %0d)", m, cyc);
        end else begin
            if (m == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk($sformatf("m%0d resp cycle", m), cyc, e.due);
            chk($sformatf("m%0d rdata", m), rdata, e.rdata);
            chk($sformatf("m%0d err", m), {31'd0, err}, {31'd0, e.err});
        end
    endtask

    // Response monitor, decoupled from stimulus.
    always @(negedge clk) begin
        if (!rst) begin
            if (m0_rvalid) mon_pop(0, m0_rdata, m0_err);
            if (m1_rvalid) mon_pop(1, m1_rdata, m1_err);
        end
    end

    task automatic idle_inputs();
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_size = 2'd0; m0_unsigned = 0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_size = 2'd0; m1_unsigned = 0; m1_wdata = '0;
    endtask

    // One access from a single requester; checks the same-cycle memory port
    // and queues the expected response.
    task automatic issue(input int m, input logic we, input logic [9:0] addr,
                         input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                         input logic exp_en, input logic [3:0] exp_mask,
                         input logic [31:0] exp_store, input logic [31:0] exp_rdata,
                         input logic exp_err, input logic do_push);
        string tag;
        tag = $sformatf("m%0d %s a=%h sz=%0d", m, we ? "st" : "ld", addr, size);
        @(posedge clk); #1;
        idle_inputs();
        if (m == 0) begin
            m0_req = 1; m0_we = we; m0_addr = addr; m0_size = size; m0_unsigned = uns; m0_wdata = wdata;
        end else begin
            m1_req = 1; m1_we = we; m1_addr = addr; m1_size = size; m1_unsigned = uns; m1_wdata = wdata;
        end
        @(negedge clk);
        chk({tag, " gnt"}, {30'd0, m1_gnt, m0_gnt}, (m == 0) ? 32'd1 : 32'd2);
        chk({tag, " mem_en"}, {31'd0, mem_en}, {31'd0, exp_en});
        chk({tag, " mem_mask"}, {28'd0, mem_mask}, {28'd0, exp_mask});
        chk({tag, " mem_address"}, {24'd0, mem_address}, {24'd0, addr[9:2]});
        if (exp_en) chk({tag, " mem_storein"}, mem_storein, exp_store);
        if (do_push) push(m, exp_rdata, exp_err);
    endtask

    task automatic go_idle(input int n);
        @(posedge clk); #1;
        idle_inputs();
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_idx;
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
        chk("reset m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
        chk("reset m0_rdata", m0_rdata, 32'd0);
        chk("reset m1_err", {31'd0, m1_err}, 32'd0);
        chk("reset mem_en", {31'd0, mem_en}, 32'd0);
        chk("reset mem_mask", {28'd0, mem_mask}, 32'd0);
        chk("reset mem_storein", mem_storein, 32'd0);
        rst = 1'b0;

        //    m we addr    sz uns wdata         en mask     storein        rdata         err push
        issue(0, 1, 10'h010, 2, 0, 32'hDEADBEEF, 1, 4'b1111, 32'hDEADBEEF, 32'h00000000, 0, 1);
        issue(0, 1, 10'h013, 0, 0, 32'h000000A5, 1, 4'b1000, 32'hA5A5A5A5, 32'h00000000, 0, 1);
        issue(0, 0, 10'h013, 0, 0, 32'h0,        0, 4'b0000, 32'h0,        32'hFFFFFFA5, 0, 1);
        issue(0, 0, 10'h013, 0, 1, 32'h0,        0, 4'b0000, 32'h0,        32'h000000A5, 0, 1);
        issue(0, 1, 10'h010, 2, 0, 32'h80017FFF, 1, 4'b1111, 32'h80017FFF, 32'h00000000, 0, 1);
        issue(1, 0, 10'h012, 1, 0, 32'h0,        0, 4'b0000, 32'h0,        32'hFFFF8001, 0, 1);
        issue(0, 0, 10'h010, 1, 1, 32'h0,        0, 4'b0000, 32'h0,        32'h00007FFF, 0, 1);
        issue(1, 1, 10'h021, 1, 0, 32'h00001234, 0, 4'b0000, 32'h0,        32'h00000000, 1, 1);
        issue(1, 1, 10'h020, 3, 0, 32'h12345678, 0, 4'b0000, 32'h0,        32'h00000000, 1, 1);
        issue(0, 0, 10'h012, 2, 0, 32'h0,        0, 4'b0000, 32'h0,        32'h00000000, 1, 1);
        issue(1, 1, 10'h014, 2, 0, 32'h0000ABCD, 1, 4'b1111, 32'h0000ABCD, 32'h00000000, 0, 1);
        issue(1, 1, 10'h016, 1, 0, 32'h00001234, 1, 4'b1100, 32'h12341234, 32'h00000000, 0, 1);
        issue(0, 0, 10'h014, 2, 0, 32'h0,        0, 4'b0000, 32'h0,        32'h1234ABCD, 0, 1);
        issue(1, 0, 10'h017, 0, 0, 32'h0,        0, 4'b0000, 32'h0,        32'h00000012, 0, 1);
        issue(0, 0, 10'h016, 0, 0, 32'h0,        0, 4'b0000, 32'h0,        32'h00000034, 0, 1);
        issue(0, 0, 10'h014, 1, 0, 32'h0,        0, 4'b0000, 32'h0,        32'hFFFFABCD, 0, 1);
        issue(1, 1, 10'h011, 0, 0, 32'h0000007F, 1, 4'b0010, 32'h7F7F7F7F, 32'h00000000, 0, 1);
        issue(0, 1, 10'h000, 2, 0, 32'h11111111, 1, 4'b1111, 32'h11111111, 32'h00000000, 0, 1);
        issue(1, 1, 10'h004, 2, 0, 32'h22222222, 1, 4'b1111, 32'h22222222, 32'h00000000, 0, 1);
        go_idle(2);

        // Contention straight out of reset.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        m0_req = 1; m0_we = 0; m0_addr = 10'h000; m0_size = 2'd2;
        m1_req = 1; m1_we = 0; m1_addr = 10'h004; m1_size = 2'd2;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
`ifdef DMEM_ARB_FIXED_PRIO_EN
            exp_idx = 0;
`else
            exp_idx = i % 2;
`endif
            chk($sformatf("contend %0d gnt", i), {30'd0, m1_gnt, m0_gnt},
                (exp_idx == 0) ? 32'd1 : 32'd2);
            chk($sformatf("contend %0d mem_address", i), {24'd0, mem_address},
                (exp_idx == 0) ? 32'd0 : 32'd1);
            push(exp_idx, (exp_idx == 0) ? 32'h11111111 : 32'h22222222, 1'b0);
            if (i < 3) @(posedge clk);
        end
        go_idle(2);

        // Reset landing on the response cycle of an m0 load.
        issue(0, 0, 10'h000, 2, 0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 0, 0);
        @(posedge clk); #1;
        idle_inputs();
        rst = 1'b1;
        #1;
        chk("rst mid m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
        chk("rst mid m0_rdata", m0_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        m0_req = 1; m0_we = 0; m0_addr = 10'h000; m0_size = 2'd2;
        m1_req = 1; m1_we = 0; m1_addr = 10'h004; m1_size = 2'd2;
        @(negedge clk);
        chk("post-rst contend gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
        push(0, 32'h11111111, 1'b0);
        go_idle(3);

        chk("m0 queue drained", q0.size(), 32'd0);
        chk("m1 queue drained", q1.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester access controller for the 256-word x 32-bit byte-masked data memory.
- Requester 0 is the core load/store unit; requester 1 is a debug/DMA port.
- Arbitrates round-robin, converts byte address and access size into word index, write lane mask and lane-replicated store data, and detects misaligned accesses.
- Returns a registered, sign/zero-extended load result one cycle after grant.

Parameters:
- ADDR_W, 10, byte address width; word index = addr[ADDR_W-1:2], must equal 8 bits at default.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- m0_req  in  1  requester 0 access request, held until granted
- m0_we  in  1  1 = store, 0 = load
- m0_addr  in  ADDR_W  byte address
- m0_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- m0_unsigned  in  1  zero-extend load (lbu/lhu)
- m0_wdata  in  32  store data, LSB-aligned
- m0_gnt  out  1  access accepted this cycle (combinational)
- m0_rvalid  out  1  response pulse, cycle after grant
- m0_rdata  out  32  formatted load data, valid with m0_rvalid
- m0_err  out  1  misaligned/illegal flag, valid with m0_rvalid
- m1_*  identical set for requester 1
- mem_en  out  1  memory write enable
- mem_address  out  8  word index
- mem_storein  out  32  lane-replicated store data
- mem_mask  out  4  byte lane mask
- mem_loadout  in  32  memory read data (combinational read of mem_address)

Behaviour:
- Reset (async, rst=1): all gnt/rvalid/err = 0, rdata = 0, rr_last = 1 (requester 0 wins first contention). mem_en = 0, mem_address = 0, mem_mask = 0, mem_storein = 0 while no grant.
- Arbitration (combinational, every cycle):
  - Only one req high: that requester is granted.
  - Both high: grant the requester != rr_last.
  - rr_last updates to the granted index at posedge.
  - No req: no grant, rr_last holds.
- One access per cycle; no back-pressure on responses.
- Granted requester drives mem_address = addr[9:2]; off = addr[1:0].
- Misaligned = (size==1 && off[0]) || (size==2 && off!=0) || size==3. On misalign: mem_en = 0, mem_mask = 0; still granted.
- Store, aligned: mem_en = 1.
  - byte: mask = 4'b0001<<off, storein = {4{wdata[7:0]}}.
  - half: mask = off[1] ? 4'b1100 : 4'b0011, storein = {2{wdata[15:0]}}.
  - word: mask = 4'b1111, storein = wdata.
- Load: mem_en = 0. Memory is read combinationally in the grant cycle, then:
  - byte: lane = loadout >> (8*off).
  - half: lane = loadout >> (16*off[1]).
  - Extension to 32 bits: sign-extend unless unsigned.
  - Result registered at posedge.
- Response: rvalid pulses exactly 1 cycle after gnt for the same requester, for loads and stores. Store rdata = 0. err = registered misalign. On error, rdata = 0.
- Back-to-back: a requester may hold req high; it is regranted every cycle it wins. Under continuous contention, grants alternate 0,1,0,1.
- rst asserted mid-operation: pending rvalid dropped immediately, no response for that access. A store granted in the same cycle as rst assertion has undefined effect on memory.
- Pipelined responses from consecutive grants appear on consecutive cycles.

Optional Feature:
- Macro DMEM_ARB_FIXED_PRIO_EN.
  - Defined: requester 0 always wins contention; rr_last is not implemented; requester 1 is granted only when m0_req = 0.
  - Undefined: round-robin as above.

Test Plan:
- Reset, then m0 sw addr 0x010 wdata 0xDEADBEEF -> gnt same cycle, mem_en=1, mem_address=0x04, mask=4'b1111; next cycle m0_rvalid=1, err=0.
- m0 sb addr 0x013 wdata 0x000000A5 -> mask=4'b1000, storein=0xA5A5A5A5. Then lb 0x013 -> rdata=0xFFFFFFA5; lbu 0x013 -> rdata=0x000000A5.
- Word 0x04 = 0x80017FFF; lh 0x012 -> 0xFFFF8001; lhu 0x010 -> 0x00007FFF.
- m1 sh addr 0x021 -> gnt=1, mem_en=0, mask=0; next cycle m1_rvalid=1, m1_err=1, rdata=0. Size 3 behaves the same.
- Both req held 4 cycles after reset -> grant order m0,m1,m0,m1; rvalid sequence lags by 1 cycle. With DMEM_ARB_FIXED_PRIO_EN: m0 on all 4 cycles, m1 never granted.
- Assert rst the cycle after an m0 load grant -> m0_rvalid=0 and m0_rdata=0 immediately; after release, first contention is granted to m0.
